// File: rtl/buffer_loader_if.sv
// Packet handshake between the sender and buffer_loader.
// Ports: in_valid/in_data/in_sel from sender, in_ready back to it.
interface buffer_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic [1:0] in_sel;

  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    output in_ready
  );
endinterface

// File: rtl/buffer_loader.sv
// Loads 2-bit packets into four 6-entry shift queues for the reader.
// Ports: clk, rst (sync, active-high), in_if (valid/ready packet),
//   pop[3:0] per-queue pop, buffer1_o..buffer4_o packed queues
//   (entry i at [3i+2:3i], bit 3i = valid), occ1..occ4 occupancy,
//   drop_count saturating count of entries lost to overwrite.
module buffer_loader #(
  parameter bit OVERWRITE = 1'b0,
  parameter int DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  buffer_loader_if.slave    in_if,
  input  logic [3:0]        pop,
  output logic [17:0]       buffer1_o,
  output logic [17:0]       buffer2_o,
  output logic [17:0]       buffer3_o,
  output logic [17:0]       buffer4_o,
  output logic [2:0]        occ1,
  output logic [2:0]        occ2,
  output logic [2:0]        occ3,
  output logic [2:0]        occ4,
  output logic [DROP_W-1:0] drop_count
);

  logic [17:0]       q_r   [4];
  logic [17:0]       q_n   [4];
  logic [2:0]        occ_r [4];
  logic [2:0]        occ_n [4];
  logic [2:0]        tail  [4];
  logic [3:0]        do_pop;
  logic [3:0]        do_push;
  logic [3:0]        ovf;
  logic [3:0]        shift;
  logic              accept;
  logic              ovw;
  logic [DROP_W-1:0] drop_r;

  // A pop on the target queue frees a slot in the same cycle,
  // so a full queue can still take a packet when it is popped.
  always_comb begin
    if (OVERWRITE) begin
      in_if.in_ready = 1'b1;
    end else begin
      in_if.in_ready = (occ_r[in_if.in_sel] < 3'd6)
                    || pop[in_if.in_sel];
    end
  end

  assign accept = in_if.in_valid && in_if.in_ready;

  // Pop first, then push at the post-pop tail. An overwrite is
  // a push into a full, un-popped queue: treat it as an implicit
  // head pop so the new packet lands at entry 5.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      do_push[k] = accept && (in_if.in_sel == 2'(k));
      do_pop[k]  = pop[k] && (occ_r[k] != 3'd0);
      ovf[k]     = do_push[k] && !pop[k]
                && (occ_r[k] == 3'd6);
      shift[k]   = do_pop[k] || ovf[k];
      q_n[k]     = shift[k] ? {3'b000, q_r[k][17:3]} : q_r[k];
      tail[k]    = occ_r[k] - {2'b00, shift[k]};
      occ_n[k]   = tail[k];
      if (do_push[k]) begin
        occ_n[k] = tail[k] + 3'd1;
        for (int i = 0; i < 6; i++) begin
          if (tail[k] == 3'(i)) begin
            q_n[k][3*i +: 3] = {in_if.in_data, 1'b1};
          end
        end
      end
    end
    ovw = |ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        q_r[k]   <= '0;
        occ_r[k] <= '0;
      end
      drop_r <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        q_r[k]   <= q_n[k];
        occ_r[k] <= occ_n[k];
      end
      if (ovw && (drop_r != {DROP_W{1'b1}})) begin
        drop_r <= drop_r + DROP_W'(1);
      end
    end
  end

  assign buffer1_o  = q_r[0];
  assign buffer2_o  = q_r[1];
  assign buffer3_o  = q_r[2];
  assign buffer4_o  = q_r[3];
  assign occ1       = occ_r[0];
  assign occ2       = occ_r[1];
  assign occ3       = occ_r[2];
  assign occ4       = occ_r[3];
  assign drop_count = drop_r;

endmodule

// File: tb/tb_buffer_loader.sv
// Bench for buffer_loader: stall-mode and overwrite-mode instances
// driven with shared stimulus, checked against a queue model.
module tb_buffer_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pop;

  logic [17:0] buf0 [4];
  logic [17:0] buf1 [4];
  logic [2:0]  occ0 [4];
  logic [2:0]  occ1 [4];
  logic [7:0]  drop0;
  logic [1:0]  drop1;

  buffer_loader_if if0 ();
  buffer_loader_if if1 ();

  always #5 clk = ~clk;

  buffer_loader #(.OVERWRITE(1'b0), .DROP_W(8)) u_stall (
    .clk(clk), .rst(rst), .in_if(if0), .pop(pop),
    .buffer1_o(buf0[0]), .buffer2_o(buf0[1]),
    .buffer3_o(buf0[2]), .buffer4_o(buf0[3]),
    .occ1(occ0[0]), .occ2(occ0[1]),
    .occ3(occ0[2]), .occ4(occ0[3]),
    .drop_count(drop0)
  );

  buffer_loader #(.OVERWRITE(1'b1), .DROP_W(2)) u_ovw (
    .clk(clk), .rst(rst), .in_if(if1), .pop(pop),
    .buffer1_o(buf1[0]), .buffer2_o(buf1[1]),
    .buffer3_o(buf1[2]), .buffer4_o(buf1[3]),
    .occ1(occ1[0]), .occ2(occ1[1]),
    .occ3(occ1[2]), .occ4(occ1[3]),
    .drop_count(drop1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: queue index m*4+k, m=0 stall, m=1 overwrite
  logic [1:0] mq [8][$];
  int         mdrop [2];
  int         dmax  [2];

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic [1:0] s;
    logic [3:0] p;
    logic       r;
    logic [17:0] eb;
    logic [2:0]  eo;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] pack(input int idx);
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < mq[idx].size(); i++)
      r[3*i +: 3] = {mq[idx][i], 1'b1};
    return r;
  endfunction

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("buf m%0d q%0d", m, k),
            32'(m == 0 ? buf0[k] : buf1[k]), 32'(pack(m*4+k)));
        chk($sformatf("occ m%0d q%0d", m, k),
            32'(m == 0 ? occ0[k] : occ1[k]),
            32'(mq[m*4+k].size()));
      end
      chk($sformatf("drop m%0d", m),
          m == 0 ? 32'(drop0) : 32'(drop1), 32'(mdrop[m]));
    end
  endtask

  task automatic step(input logic v, input logic [1:0] d,
                      input logic [1:0] s, input logic [3:0] p,
                      input logic r);
    logic rdy;
    int   idx;
    @(negedge clk);
    rst = r;
    pop = p;
    if0.in_valid = v; if0.in_data = d; if0.in_sel = s;
    if1.in_valid = v; if1.in_data = d; if1.in_sel = s;
    #1;
    for (int m = 0; m < 2; m++) begin
      rdy = (m == 1) || (mq[m*4+s].size() < 6) || p[s];
      chk($sformatf("in_ready m%0d", m),
          32'(m == 0 ? if0.in_ready : if1.in_ready), 32'(rdy));
      if (r) begin
        for (int k = 0; k < 4; k++) mq[m*4+k].delete();
        mdrop[m] = 0;
      end else begin
        for (int k = 0; k < 4; k++)
          if (p[k] && mq[m*4+k].size() > 0)
            void'(mq[m*4+k].pop_front());
        if (v && rdy) begin
          idx = m*4 + s;
          if (mq[idx].size() == 6) begin
            void'(mq[idx].pop_front());
            if (mdrop[m] < dmax[m]) mdrop[m]++;
          end
          mq[idx].push_back(d);
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] s);
    step(1'b1, d, s, 4'b0000, 1'b0);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 2'd0, 2'd0, 4'b0000, r);
  endtask

  initial begin
    dmax[0] = 255;
    dmax[1] = 3;
    mdrop[0] = 0;
    mdrop[1] = 0;
    rst = 1'b1;
    pop = 4'b0;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_sel = '0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_sel = '0;
    repeat (2) @(posedge clk);

    // reset, fill queue1 with 1,2,3, pop it past empty
    tbl[0] = '{1'b0, 2'd0, 2'd0, 4'b0000, 1'b1, 18'h0,     3'd0};
    tbl[1] = '{1'b1, 2'd1, 2'd0, 4'b0000, 1'b0, 18'h3,     3'd1};
    tbl[2] = '{1'b1, 2'd2, 2'd0, 4'b0000, 1'b0, 18'h2B,    3'd2};
    tbl[3] = '{1'b1, 2'd3, 2'd0, 4'b0000, 1'b0, 18'h1EB,   3'd3};
    tbl[4] = '{1'b0, 2'd0, 2'd0, 4'b0001, 1'b0, 18'h3D,    3'd2};
    tbl[5] = '{1'b0, 2'd0, 2'd0, 4'b0001, 1'b0, 18'h7,     3'd1};
    tbl[6] = '{1'b0, 2'd0, 2'd0, 4'b0001, 1'b0, 18'h0,     3'd0};
    tbl[7] = '{1'b0, 2'd0, 2'd0, 4'b0001, 1'b0, 18'h0,     3'd0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].p, tbl[i].r);
      chk($sformatf("tbl%0d buf1", i), 32'(buf0[0]), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d occ1", i), 32'(occ0[0]), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d buf1 ovw", i), 32'(buf1[0]),
          32'(tbl[i].eb));
    end
    chk("reset ready m0", 32'(if0.in_ready), 32'd1);

    // stall when full, then pop-with-push on the full queue
    idle(1'b1);
    for (int i = 0; i < 6; i++) push(2'(i % 4), 2'd1);
    step(1'b1, 2'd2, 2'd1, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 2'd1, 4'b0000, 1'b0);
    chk("stall ready", 32'(if0.in_ready), 32'd0);
    chk("stall buf2", 32'(buf0[1]),
        32'(18'b011_001_111_101_011_001));
    step(1'b1, 2'd2, 2'd1, 4'b0010, 1'b0);
    chk("poppush buf2", 32'(buf0[1]),
        32'(18'b101_011_001_111_101_011));
    chk("poppush occ2", 32'(occ0[1]), 32'd6);
    chk("poppush drop", 32'(drop0), 32'd0);

    // overwrite-oldest and drop counter saturation
    idle(1'b1);
    for (int i = 0; i < 6; i++) push(2'(i % 4), 2'd2);
    push(2'd2, 2'd2);
    chk("ovw buf3", 32'(buf1[2]),
        32'(18'b101_011_001_111_101_011));
    chk("ovw occ3", 32'(occ1[2]), 32'd6);
    chk("ovw drop1", 32'(drop1), 32'd1);
    for (int i = 0; i < 4; i++) push(2'(i), 2'd2);
    chk("ovw drop sat", 32'(drop1), 32'd3);

    // all four pops with a push to queue4
    idle(1'b1);
    for (int k = 0; k < 4; k++) begin
      push(2'd1, 2'(k));
      push(2'd2, 2'(k));
    end
    step(1'b1, 2'd3, 2'd3, 4'b1111, 1'b0);
    chk("sim occ1", 32'(occ0[0]), 32'd1);
    chk("sim occ3", 32'(occ0[2]), 32'd1);
    chk("sim occ4", 32'(occ0[3]), 32'd2);
    chk("sim buf4", 32'(buf0[3]), 32'(18'b111_101));

    // reset in the middle of a push/pop burst
    push(2'd3, 2'd0);
    step(1'b1, 2'd1, 2'd2, 4'b0011, 1'b0);
    step(1'b1, 2'd2, 2'd0, 4'b1010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst buf m0 q%0d", k), 32'(buf0[k]), 32'd0);
      chk($sformatf("rst buf m1 q%0d", k), 32'(buf1[k]), 32'd0);
      chk($sformatf("rst occ m0 q%0d", k), 32'(occ0[k]), 32'd0);
    end
    chk("rst drop m1", 32'(drop1), 32'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
